// File: rtl/axis_ingress_port_arbiter.sv
// Frame-atomic round-robin merge of per-port AXI-Stream RX frames into one fabric stream,
// with a per-frame stall watchdog that truncates a starved frame and drains its remainder.
module axis_ingress_port_arbiter #(
  parameter int NUM_PORTS      = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PORT_BITS      = $clog2(NUM_PORTS)
) (
  input  logic                            clk_fabric,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            link_up,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  output logic [NUM_PORTS-1:0]            s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tuser,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tuser,
  output logic                            m_tlast,
  output logic [PORT_BITS-1:0]            m_tid,
  output logic [15:0]                     timeout_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_ABORT, ST_DRAIN} state_t;

  localparam logic [PORT_BITS:0] NP_W = (PORT_BITS+1)'(NUM_PORTS);

  state_t                 state_q, state_d;
  logic [PORT_BITS-1:0]   rr_q, rr_d;
  logic [PORT_BITS-1:0]   gnt_q, gnt_d;
  logic [15:0]            idle_cnt_q, idle_cnt_d;
  logic [15:0]            timeout_cnt_q, timeout_cnt_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
  logic                   m_tuser_q, m_tuser_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [PORT_BITS-1:0]   m_tid_q, m_tid_d;

  logic [DATA_WIDTH-1:0]  port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]   eligible;
  logic                   out_free;
  logic                   sel_valid, sel_user, sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   found;
  logic [PORT_BITS-1:0]   pick;
  logic [PORT_BITS:0]     srch_sum;
  logic [PORT_BITS-1:0]   srch_idx;

  assign out_free  = !m_tvalid_q || m_tready;
  assign eligible  = s_tvalid & link_up;
  assign sel_valid = s_tvalid[gnt_q];
  assign sel_user  = s_tuser[gnt_q];
  assign sel_last  = s_tlast[gnt_q];
  assign sel_data  = port_data[gnt_q];

  // Only the granted port is ever ready, so s_tready is one-hot or zero.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_data[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign s_tready[gi]  = (gnt_q == PORT_BITS'(gi)) &&
                             (((state_q == ST_PASS) && out_free) || (state_q == ST_DRAIN));
    end
  endgenerate

  // Round-robin search starting one past the last grant, wrapping at NUM_PORTS.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    srch_sum = '0;
    srch_idx = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      srch_sum = {1'b0, rr_q} + (PORT_BITS+1)'(off);
      if (srch_sum >= NP_W) srch_sum = srch_sum - NP_W;
      srch_idx = srch_sum[PORT_BITS-1:0];
      if (!found && eligible[srch_idx]) begin
        found = 1'b1;
        pick  = srch_idx;
      end
    end
  end

  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_q          <= PORT_BITS'(NUM_PORTS - 1);
      gnt_q         <= '0;
      idle_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= '0;
      m_tuser_q     <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tid_q       <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      gnt_q         <= gnt_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tdata_q     <= m_tdata_d;
      m_tuser_q     <= m_tuser_d;
      m_tlast_q     <= m_tlast_d;
      m_tid_q       <= m_tid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d      = pick;
          rr_d       = pick;
          idle_cnt_d = '0;
          state_d    = ST_PASS;
        end
      end
      ST_PASS: begin
        // Backpressure with valid high holds the watchdog; only starvation counts.
        if (sel_valid) begin
          if (out_free) begin
            idle_cnt_d = '0;
            if (sel_last) state_d = ST_IDLE;
          end
        end else if (idle_cnt_q == 16'(TIMEOUT_CYCLES)) begin
          state_d = ST_ABORT;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      ST_ABORT: begin
        if (out_free) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (sel_valid && sel_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_tvalid_d    = m_tvalid_q && !m_tready;
    m_tdata_d     = m_tdata_q;
    m_tuser_d     = m_tuser_q;
    m_tlast_d     = m_tlast_q;
    m_tid_d       = m_tid_q;
    timeout_cnt_d = timeout_cnt_q;
    if ((state_q == ST_PASS) && sel_valid && out_free) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = sel_data;
      m_tuser_d  = sel_user;
      m_tlast_d  = sel_last;
      m_tid_d    = gnt_q;
    end else if ((state_q == ST_ABORT) && out_free) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = '0;
      m_tuser_d  = 1'b1;
      m_tlast_d  = 1'b1;
      m_tid_d    = gnt_q;
      if (timeout_cnt_q != 16'hFFFF) timeout_cnt_d = timeout_cnt_q + 16'd1;
    end
  end

  assign m_tvalid      = m_tvalid_q;
  assign m_tdata       = m_tdata_q;
  assign m_tuser       = m_tuser_q;
  assign m_tlast       = m_tlast_q;
  assign m_tid         = m_tid_q;
  assign timeout_count = timeout_cnt_q;

endmodule

// File: tb/tb_axis_ingress_port_arbiter.sv
// Randomized and directed bench for axis_ingress_port_arbiter: per-port source queues feed the
// DUT, and a per-port expected-beat scoreboard plus frame/order trackers judge the merged stream.
module tb_axis_ingress_port_arbiter;
  localparam int NP = 12;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int PB = $clog2(NP);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        link_up, s_tvalid, s_tready, s_tuser, s_tlast;
  logic [NP*DW-1:0]     s_tdata;
  logic                 m_tvalid, m_tready, m_tuser, m_tlast;
  logic [DW-1:0]        m_tdata;
  logic [PB-1:0]        m_tid;
  logic [15:0]          timeout_count;

  axis_ingress_port_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_fabric(clk), .rst(rst), .link_up(link_up),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tid(m_tid),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  beat_t src_q [NP][$];
  beat_t exp_q [NP][$];

  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            vprob = 100;
  int            rdy_mode = 1;
  bit            lat_en = 1'b1;
  bit            chk_bubble = 1'b0;
  logic [NP-1:0] consumed = '0;
  logic [NP-1:0] seen_rdy = '0;
  int            hs_cyc [NP];
  bit            pend_lat = 1'b0;
  logic [63:0]   pend_beat;
  bit            prev_hold = 1'b0;
  logic [63:0]   prev_beat;
  bit            in_frame = 1'b0;
  bit            have_last = 1'b0;
  int            lock_port = 0;
  int            last_tlast_cyc = 0;
  int            last_out_cyc = 0;
  int            ord_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] out_word();
    return 64'({m_tid, m_tdata, m_tuser, m_tlast});
  endfunction

  function automatic bit all_idle();
    for (int p = 0; p < NP; p++)
      if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
    return !m_tvalid;
  endfunction

  task automatic push_frame(input int p, input int n, input logic [DW-1:0] base,
                            input bit to_exp, input bit rnd_user);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.user = rnd_user ? 1'($urandom_range(1)) : 1'b0;
      b.last = (i == n - 1);
      src_q[p].push_back(b);
      if (to_exp) exp_q[p].push_back(b);
    end
  endtask

  task automatic accept_out();
    int    t;
    beat_t e;
    t = int'(m_tid);
    $display("beat cyc=%0d tid=%0d data=%08h user=%0b last=%0b", cyc, t, m_tdata, m_tuser, m_tlast);
    if (in_frame) check("frame_atomic", 64'(t), 64'(lock_port));
    else begin
      ord_q.push_back(t);
      if (chk_bubble && have_last) check("frame_gap", 64'(cyc - last_tlast_cyc), 64'd2);
    end
    lock_port = t;
    in_frame  = !m_tlast;
    if (m_tlast) begin
      last_tlast_cyc = cyc;
      have_last      = 1'b1;
    end
    last_out_cyc = cyc;
    if (t >= NP || exp_q[t].size() == 0) check("unexpected_beat", out_word(), '1);
    else begin
      e = exp_q[t].pop_front();
      check("out_beat", 64'({m_tdata, m_tuser, m_tlast}), 64'(e));
    end
  endtask

  // One fabric cycle: check registered outputs, update sources, then predict this edge's handshakes.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (pend_lat) begin
      check("lat_valid", 64'(m_tvalid), 64'd1);
      check("lat_beat", out_word(), pend_beat);
      pend_lat = 1'b0;
    end
    if (prev_hold) begin
      check("hold_valid", 64'(m_tvalid), 64'd1);
      check("hold_beat", out_word(), prev_beat);
    end
    for (int p = 0; p < NP; p++) begin
      if (consumed[p]) begin
        void'(src_q[p].pop_front());
        s_tvalid[p] = 1'b0;
      end
      if (src_q[p].size() != 0) begin
        if (!s_tvalid[p]) s_tvalid[p] = ($urandom_range(99) < vprob);
        s_tdata[p*DW +: DW] = src_q[p][0].data;
        s_tuser[p]          = src_q[p][0].user;
        s_tlast[p]          = src_q[p][0].last;
      end else begin
        s_tvalid[p]         = 1'b0;
        s_tdata[p*DW +: DW] = $urandom;
        s_tuser[p]          = 1'($urandom_range(1));
        s_tlast[p]          = 1'($urandom_range(1));
      end
    end
    consumed = '0;
    case (rdy_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = ($urandom_range(99) < 60);
    endcase
    #1;
    check("ready_onehot", 64'($countones(s_tready) <= 1), 64'd1);
    seen_rdy |= s_tready;
    for (int p = 0; p < NP; p++) begin
      if (s_tvalid[p] && s_tready[p]) begin
        consumed[p] = 1'b1;
        hs_cyc[p]   = cyc;
        if (lat_en) begin
          pend_lat  = 1'b1;
          pend_beat = 64'({PB'(p), src_q[p][0].data, src_q[p][0].user, src_q[p][0].last});
        end
      end
    end
    if (m_tvalid && m_tready) accept_out();
    prev_hold = m_tvalid && !m_tready;
    prev_beat = out_word();
  endtask

  task automatic run_idle(input string tag, input int max);
    int n = 0;
    while (!all_idle() && n < max) begin
      step();
      n++;
    end
    check(tag, 64'(all_idle()), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    s_tvalid = '0;
    m_tready = 1'b0;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
    end
    consumed  = '0;
    pend_lat  = 1'b0;
    prev_hold = 1'b0;
    in_frame  = 1'b0;
    have_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_beat", out_word(), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_timeout_count", 64'(timeout_count), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    beat_t b;
    int    n;
    int    exp_ord [6] = '{0, 5, 11, 0, 5, 11};
    rst = 1'b1; link_up = '1; s_tvalid = '0; s_tdata = '0; s_tuser = '0; s_tlast = '0;
    m_tready = 1'b0;
    do_reset();

    // Single port 3 frame, full throughput.
    push_frame(3, 4, 32'hA0, 1'b1, 1'b0);
    run_idle("p3_frame_done", 50);
    check("p3_granted", 64'(ord_q.size() > 0 ? ord_q[0] : -1), 64'd3);

    // Port 2 stalls after one beat: watchdog truncates, remainder is drained.
    b = '{data: 32'hB0, user: 1'b0, last: 1'b0};
    src_q[2].push_back(b);
    exp_q[2].push_back(b);
    n = 0;
    while (src_q[2].size() != 0 && n < 50) begin step(); n++; end
    lat_en = 1'b0;
    b = '{data: '0, user: 1'b1, last: 1'b1};
    exp_q[2].push_back(b);
    n = 0;
    while (exp_q[2].size() != 0 && n < 60) begin step(); n++; end
    check("abort_latency", 64'(last_out_cyc - hs_cyc[2]), 64'(TO + 3));
    check("timeout_count_1", 64'(timeout_count), 64'd1);
    for (int i = 1; i < 4; i++) begin
      b = '{data: 32'hB0 + DW'(i), user: 1'b0, last: (i == 3)};
      src_q[2].push_back(b);
    end
    run_idle("p2_drained", 100);
    lat_en = 1'b1;
    push_frame(2, 2, 32'hC0, 1'b1, 1'b0);
    run_idle("p2_next_frame", 50);

    // Long output backpressure mid-frame must not trip the watchdog.
    push_frame(6, 4, 32'hD0, 1'b1, 1'b0);
    n = 0;
    while (exp_q[6].size() > 3 && n < 30) begin step(); n++; end
    rdy_mode = 0;
    repeat (100) step();
    check("bp_valid_held", 64'(m_tvalid), 64'd1);
    check("bp_no_abort", 64'(timeout_count), 64'd1);
    rdy_mode = 1;
    run_idle("bp_frame_done", 50);

    // Link-down port is skipped; dropping link mid-frame does not cut the frame.
    link_up = '1;
    link_up[7] = 1'b0;
    seen_rdy = '0;
    push_frame(7, 2, 32'hE0, 1'b1, 1'b0);
    push_frame(8, 3, 32'hF0, 1'b1, 1'b0);
    n = 0;
    while (exp_q[8].size() > 2 && n < 30) begin step(); n++; end
    link_up[8] = 1'b0;
    n = 0;
    while (exp_q[8].size() != 0 && n < 30) begin step(); n++; end
    check("p8_complete", 64'(exp_q[8].size()), 64'd0);
    repeat (20) step();
    check("p7_never_ready", 64'(seen_rdy[7]), 64'd0);
    check("p7_pending", 64'(exp_q[7].size()), 64'd2);
    link_up = '1;
    run_idle("p7_after_link", 50);

    // Reset in the middle of a port 4 frame.
    push_frame(4, 6, 32'h40, 1'b1, 1'b0);
    n = 0;
    while (exp_q[4].size() > 4 && n < 30) begin step(); n++; end
    do_reset();

    // Round-robin order from port 0 with one idle cycle between frames.
    ord_q.delete();
    chk_bubble = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push_frame(0, 2, 32'h100 + DW'(r * 16), 1'b1, 1'b0);
      push_frame(5, 2, 32'h500 + DW'(r * 16), 1'b1, 1'b0);
      push_frame(11, 2, 32'hB00 + DW'(r * 16), 1'b1, 1'b0);
    end
    run_idle("rr_frames_done", 100);
    chk_bubble = 1'b0;
    check("rr_frame_count", 64'(ord_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      check("rr_order", 64'(i < ord_q.size() ? ord_q[i] : -1), 64'(exp_ord[i]));

    // Random traffic with valid gaps and random output backpressure.
    vprob = 70;
    rdy_mode = 2;
    for (int f = 0; f < 40; f++)
      push_frame(int'($urandom_range(NP - 1)), int'($urandom_range(6, 1)), $urandom, 1'b1, 1'b1);
    run_idle("random_drain", 20000);
    check("random_no_timeout", 64'(timeout_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_ingress_port_arbiter.md
Name: axis_ingress_port_arbiter

Overview:
- Merges the per-port AXI-Stream RX frames from the SMPM quad's CDC FIFOs into one stream for the switch fabric.
- Runs entirely in the clk_fabric domain; sits directly downstream of the CDC FIFOs.
- Frame-atomic round-robin arbitration; output tagged with source port index in m_tid.
- Per-frame stall watchdog: a stalled frame is truncated with an error flag and its remainder is discarded.

Parameters:
- NUM_PORTS, 12, number of ingress ports.
- DATA_WIDTH, 32, tdata width per port.
- TIMEOUT_CYCLES, 1024, consecutive mid-frame starvation cycles before abort; range 2..65535.
- PORT_BITS, $clog2(NUM_PORTS), width of m_tid. Derived; do not override.

Ports:
- clk_fabric  in  1  fabric clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- link_up  in  NUM_PORTS  per-port link state; a port is grant-eligible only when its bit is 1.
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tready  out  NUM_PORTS  per-port ready.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- s_tuser  in  NUM_PORTS  per-port error flag, sampled per beat.
- s_tlast  in  NUM_PORTS  per-port end of frame.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  DATA_WIDTH  output data.
- m_tuser  out  1  error flag.
- m_tlast  out  1  end of frame.
- m_tid  out  PORT_BITS  source port of the current beat.
- timeout_count  out  16  saturating count of watchdog aborts.

Behaviour:
- Reset values:
  - m_tvalid=0; m_tdata, m_tuser, m_tlast, m_tid = 0.
  - s_tready=0; timeout_count=0.
  - State IDLE; round-robin pointer rr=NUM_PORTS-1, so port 0 has first priority.
  - idle counter = 0.
  - Reset mid-frame discards everything in flight; no tlast is emitted for the truncated frame.
- Output register: single stage. It is free when !m_tvalid || m_tready. A loaded beat is held stable until accepted. Latency from input handshake to m_tvalid is 1 cycle.
- State IDLE:
  - Eligible ports are those with s_tvalid & link_up.
  - Search from rr+1 with wrap modulo NUM_PORTS; the first eligible port becomes gnt.
  - Next cycle: rr<=gnt, state PASS, idle counter=0.
  - s_tready=0 for all ports in IDLE, so there is a 1-cycle bubble between frames.
- State PASS:
  - s_tready[gnt] = output register free; all other s_tready = 0.
  - On handshake: load s_tdata/s_tuser/s_tlast of gnt into the output register, m_tid=gnt, idle counter=0.
  - If tlast was accepted: next state IDLE.
  - Idle counter increments only in cycles where s_tvalid[gnt]=0. Backpressure-only cycles (valid=1, output register not free) hold the counter.
  - link_up[gnt] falling mid-frame has no effect; the frame completes or times out.
- Abort:
  - Triggered when idle counter == TIMEOUT_CYCLES and s_tvalid[gnt]=0 in that cycle. If s_tvalid[gnt]=1 in that cycle, the beat is taken normally and no abort occurs.
  - On trigger: state ABORT. When the output register is free, load a synthetic beat: tdata=0, tuser=1, tlast=1, tid=gnt. Increment timeout_count, saturating at 16'hFFFF. Next state DRAIN.
- State DRAIN:
  - s_tready[gnt]=1 unconditionally; beats are discarded and nothing goes to the output.
  - On accepted tlast: next state IDLE.
  - No timeout applies while draining.
- Port count: NUM_PORTS is not required to be a power of two; rr wraps from NUM_PORTS-1 to 0.
- At most one s_tready bit is high in any cycle.

Test Plan:
- Port 3 only, 4-beat frame (0xA0..0xA3), m_tready=1 -> same 4 words with tid=3, tlast on 4th beat only, each beat one cycle after its input handshake.
- Ports 0, 5 and 11 each hold a 2-beat frame continuously -> grant order 0,5,11,0,5,11; never interleaved within a frame; 1 idle cycle between frames.
- Port 2 sends beat 1 then stalls, TIMEOUT_CYCLES=16 -> after 16 idle cycles, synthetic beat {tdata=0, tuser=1, tlast=1, tid=2}; timeout_count=1; remaining 3 beats + tlast from port 2 are accepted and dropped; next frame from port 2 passes normally.
- m_tready held low 100 cycles mid-frame, TIMEOUT_CYCLES=16 -> no abort, output beat stable the whole time, frame completes intact.
- link_up[7]=0 with s_tvalid[7]=1, port 8 valid -> port 8 granted, port 7 never granted. Drop link_up[8] mid-frame -> frame still completes.
- Assert rst mid-frame on port 4 -> next cycle m_tvalid=0 and all s_tready=0; the next grant search starts at port 0.
